// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS-subset core.
// Optional build macro MIPS_DEBUG_PORT_EN is handled in the core and register file.
package mips_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        LOADIR = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // 32-bit wrapping ALU; SLT compares as two's complement.
    function automatic logic [31:0] alu_compute(input alu_op_t op,
                                                input logic [31:0] x,
                                                input logic [31:0] y);
        logic [31:0] res;
        case (op)
            ALU_ADD: res = x + y;
            ALU_SUB: res = x - y;
            ALU_AND: res = x & y;
            ALU_OR:  res = x | y;
            ALU_SLT: res = {31'd0, ($signed(x) < $signed(y))};
            default: res = x + y;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two async read ports, one sync write port, R0 fixed at zero.
// With MIPS_DEBUG_PORT_EN a third async read port is added for board display.
module mips_regfile
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
`ifdef MIPS_DEBUG_PORT_EN
    input  logic [4:0]  dbg_sel,
    output logic [31:0] dbg_data,
`endif
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs_data = (rs_addr == 5'd0) ? 32'd0 : regs[rs_addr];
    assign rt_data = (rt_addr == 5'd0) ? 32'd0 : regs[rt_addr];

`ifdef MIPS_DEBUG_PORT_EN
    assign dbg_data = (dbg_sel == 5'd0) ? 32'd0 : regs[dbg_sel];
`endif

endmodule

// File: rtl/mips_multi_core.sv
// Multicycle MIPS-subset core: ROM fetch, stall-handshaked cache loads/stores.
// Defining MIPS_DEBUG_PORT_EN adds dbg_sel/dbg_data/dbg_state ports.
module mips_multi_core
    import mips_pkg::*;
#(
    parameter int PC_W     = 10,
    parameter int ADDR_W   = 12,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_data,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       data,
    output logic              r_en,
    output logic              w_en,
    input  logic              stall,
    input  logic [31:0]       saida_cache,
`ifdef MIPS_DEBUG_PORT_EN
    input  logic [4:0]        dbg_sel,
    output logic [31:0]       dbg_data,
    output logic [2:0]        dbg_state,
`endif
    output logic              illegal
);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [31:0]     ir, a, b, imm, alu_out, mdr;
    logic [31:0]     rs_data, rt_data, alu_res, wr_data;
    logic [5:0]      opcode, funct;
    logic [4:0]      rs, rt, rd, wr_addr;
    logic            known, wr_en;
    alu_op_t         alu_op;
    logic            unused_ir;

    assign opcode    = ir[31:26];
    assign rs        = ir[25:21];
    assign rt        = ir[20:16];
    assign rd        = ir[15:11];
    assign funct     = ir[5:0];
    assign imem_addr = pc;
    assign unused_ir = ^ir[25:0];

    always_comb begin
        known  = 1'b1;
        alu_op = ALU_ADD;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FUNCT_ADD: alu_op = ALU_ADD;
                FUNCT_SUB: alu_op = ALU_SUB;
                FUNCT_AND: alu_op = ALU_AND;
                FUNCT_OR:  alu_op = ALU_OR;
                FUNCT_SLT: alu_op = ALU_SLT;
                default:   known  = 1'b0;
            endcase
        end else if (!(opcode == OP_ADDI || opcode == OP_BEQ || opcode == OP_J ||
                       opcode == OP_LW   || opcode == OP_SW)) begin
            known = 1'b0;
        end
    end

    assign alu_res = alu_compute(alu_op, a, (opcode == OP_RTYPE) ? b : imm);
    assign illegal = (state == DECODE) && !known;

    // Write-back steering: lw takes MDR, everything else the ALU result.
    assign wr_en   = (state == WB);
    assign wr_addr = (opcode == OP_RTYPE) ? rd : rt;
    assign wr_data = (opcode == OP_LW) ? mdr : alu_out;

    mips_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .rs_addr (rs),
        .rt_addr (rt),
        .rs_data (rs_data),
        .rt_data (rt_data),
`ifdef MIPS_DEBUG_PORT_EN
        .dbg_sel (dbg_sel),
        .dbg_data(dbg_data),
`endif
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

`ifdef MIPS_DEBUG_PORT_EN
    assign dbg_state = state;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= PC_W'(RESET_PC);
            ir      <= 32'd0;
            a       <= 32'd0;
            b       <= 32'd0;
            imm     <= 32'd0;
            alu_out <= 32'd0;
            mdr     <= 32'd0;
            r_en    <= 1'b0;
            w_en    <= 1'b0;
            address <= '0;
            data    <= 32'd0;
        end else begin
            case (state)
                FETCH: state <= LOADIR;
                LOADIR: begin
                    ir    <= imem_data;
                    pc    <= pc + PC_W'(1);
                    state <= DECODE;
                end
                DECODE: begin
                    a   <= rs_data;
                    b   <= rt_data;
                    imm <= {{16{ir[15]}}, ir[15:0]};
                    if (!known) begin
                        state <= FETCH;
                    end else if (opcode == OP_J) begin
                        pc    <= ir[PC_W-1:0];
                        state <= FETCH;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (opcode == OP_BEQ) begin
                        if (a == b) begin
                            pc <= pc + imm[PC_W-1:0];
                        end
                        state <= FETCH;
                    end else if (opcode == OP_LW || opcode == OP_SW) begin
                        // Bus outputs are loaded here so they are stable for the whole MEM stay.
                        alu_out <= alu_res;
                        address <= alu_res[ADDR_W-1:0];
                        r_en    <= (opcode == OP_LW);
                        w_en    <= (opcode == OP_SW);
                        if (opcode == OP_SW) begin
                            data <= b;
                        end
                        state <= MEM;
                    end else begin
                        alu_out <= alu_res;
                        state   <= WB;
                    end
                end
                MEM: begin
                    if (!stall) begin
                        r_en <= 1'b0;
                        w_en <= 1'b0;
                        if (opcode == OP_LW) begin
                            mdr   <= saida_cache;
                            state <= WB;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                WB:      state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multi_core.sv
// Directed self-checking bench for mips_multi_core (default build, no debug port).
// Each task loads a small ROM program, resets the core and checks cycle-exact results.
module tb_mips_multi_core;
    import mips_pkg::*;

    logic        clk;
    logic        rst;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic [11:0] address;
    logic [31:0] data;
    logic        r_en;
    logic        w_en;
    logic        stall;
    logic [31:0] saida_cache;
    logic        illegal;
`ifdef MIPS_DEBUG_PORT_EN
    logic [4:0]  dbg_sel;
    logic [31:0] dbg_data;
    logic [2:0]  dbg_state;
`endif

    logic [31:0] rom [1024];
    int checks;
    int errors;

    mips_multi_core #(.PC_W(10), .ADDR_W(12), .RESET_PC(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .address    (address),
        .data       (data),
        .r_en       (r_en),
        .w_en       (w_en),
        .stall      (stall),
        .saida_cache(saida_cache),
`ifdef MIPS_DEBUG_PORT_EN
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data),
        .dbg_state  (dbg_state),
`endif
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data appears one cycle after the address.
    always @(posedge clk) imem_data <= rom[imem_addr];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 32'h0000_0000;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        stall = 1'b0;
        saida_cache = 32'd0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_rom();
        apply_reset();
        checks++; if (dut.state !== FETCH) begin errors++; $display("[TB] FAIL reset_state got %0d want %0d", dut.state, FETCH); end
        checks++; if (imem_addr !== 10'd0) begin errors++; $display("[TB] FAIL reset_pc got %0d want 0", imem_addr); end
        checks++; if ({r_en, w_en, illegal} !== 3'b000) begin errors++; $display("[TB] FAIL reset_ctl got %b want 000", {r_en, w_en, illegal}); end
        checks++; if (address !== 12'd0 || data !== 32'd0) begin errors++; $display("[TB] FAIL reset_bus got %h/%h want 0/0", address, data); end
    endtask

    task automatic test_alu();
        clear_rom();
        rom[0]  = 32'h2001_0005; // addi $1,$0,5
        rom[1]  = 32'h2002_FFFD; // addi $2,$0,-3
        rom[2]  = 32'h0022_1820; // add  $3,$1,$2
        rom[3]  = 32'h0041_282A; // slt  $5,$2,$1
        rom[4]  = 32'h2000_0009; // addi $0,$0,9
        rom[5]  = 32'hFC00_0000; // unknown opcode
        rom[6]  = 32'h0022_3022; // sub  $6,$1,$2
        rom[7]  = 32'h0022_3824; // and  $7,$1,$2
        rom[8]  = 32'h0022_4025; // or   $8,$1,$2
        rom[9]  = 32'h0022_482A; // slt  $9,$1,$2
        rom[10] = 32'h0000_0000; // R-type with unknown funct
        apply_reset();
        tick(15);
        checks++; if (dut.u_regfile.regs[3] !== 32'd2) begin errors++; $display("[TB] FAIL add_r3 got %h want 2", dut.u_regfile.regs[3]); end
        checks++; if (dut.u_regfile.regs[2] !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL addi_neg_r2 got %h want fffffffd", dut.u_regfile.regs[2]); end
        checks++; if (dut.state !== FETCH || imem_addr !== 10'd3) begin errors++; $display("[TB] FAIL rtype_latency got state %0d pc %0d want 0/3", dut.state, imem_addr); end
        tick(5);
        checks++; if (dut.u_regfile.regs[5] !== 32'd1) begin errors++; $display("[TB] FAIL slt_true_r5 got %h want 1", dut.u_regfile.regs[5]); end
        tick(5);
        checks++; if (dut.u_regfile.regs[0] !== 32'd0 || imem_addr !== 10'd5) begin errors++; $display("[TB] FAIL r0_write got %h pc %0d want 0/5", dut.u_regfile.regs[0], imem_addr); end
        test_illegal();
        tick(20);
        checks++; if (dut.u_regfile.regs[6] !== 32'd8) begin errors++; $display("[TB] FAIL sub_r6 got %h want 8", dut.u_regfile.regs[6]); end
        checks++; if (dut.u_regfile.regs[7] !== 32'd5) begin errors++; $display("[TB] FAIL and_r7 got %h want 5", dut.u_regfile.regs[7]); end
        checks++; if (dut.u_regfile.regs[8] !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL or_r8 got %h want fffffffd", dut.u_regfile.regs[8]); end
        checks++; if (dut.u_regfile.regs[9] !== 32'd0) begin errors++; $display("[TB] FAIL slt_false_r9 got %h want 0", dut.u_regfile.regs[9]); end
        tick(2);
        checks++; if (illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_funct got %b want 1", illegal); end
    endtask

    task automatic test_illegal();
        tick(2);
        checks++; if (illegal !== 1'b1 || dut.state !== DECODE) begin errors++; $display("[TB] FAIL illegal_pulse got %b state %0d want 1/2", illegal, dut.state); end
        tick(1);
        checks++; if (illegal !== 1'b0 || dut.state !== FETCH || imem_addr !== 10'd6) begin errors++; $display("[TB] FAIL illegal_end got %b state %0d pc %0d want 0/0/6", illegal, dut.state, imem_addr); end
        checks++; if (dut.u_regfile.regs[5] !== 32'd1) begin errors++; $display("[TB] FAIL illegal_noreg got %h want 1", dut.u_regfile.regs[5]); end
    endtask

    task automatic test_store_stall();
        clear_rom();
        rom[0] = 32'h2001_0005; // addi $1,$0,5
        rom[1] = 32'hAC01_0004; // sw   $1,4($0)
        rom[2] = 32'h8C04_0004; // lw   $4,4($0)
        apply_reset();
        tick(5);
        stall = 1'b1;
        tick(4);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (w_en !== 1'b1 || r_en !== 1'b0 || address !== 12'd4 || data !== 32'd5 || dut.state !== MEM) begin
                errors++;
                $display("[TB] FAIL sw_hold_%0d got w%b r%b addr %h data %h state %0d want w1 r0 4 5 4", c, w_en, r_en, address, data, dut.state);
            end
            if (c == 3) stall = 1'b0;
            tick(1);
        end
        checks++; if (dut.state !== FETCH || w_en !== 1'b0 || imem_addr !== 10'd2) begin errors++; $display("[TB] FAIL sw_done got state %0d w%b pc %0d want 0/0/2", dut.state, w_en, imem_addr); end
        test_load();
    endtask

    task automatic test_load();
        saida_cache = 32'h0000_1234;
        tick(4);
        checks++; if (r_en !== 1'b1 || w_en !== 1'b0 || address !== 12'd4) begin errors++; $display("[TB] FAIL lw_req got r%b w%b addr %h want r1 w0 4", r_en, w_en, address); end
        tick(1);
        checks++; if (r_en !== 1'b0 || dut.state !== WB) begin errors++; $display("[TB] FAIL lw_onecycle got r%b state %0d want 0/5", r_en, dut.state); end
        tick(1);
        checks++; if (dut.u_regfile.regs[4] !== 32'h0000_1234) begin errors++; $display("[TB] FAIL lw_r4 got %h want 1234", dut.u_regfile.regs[4]); end
        checks++; if (dut.state !== FETCH || imem_addr !== 10'd3) begin errors++; $display("[TB] FAIL lw_latency got state %0d pc %0d want 0/3", dut.state, imem_addr); end
    endtask

    task automatic test_branch_jump();
        clear_rom();
        rom[0]    = 32'h2001_0005; // addi $1,$0,5
        rom[1]    = 32'h0800_0007; // j 7
        rom[7]    = 32'h1021_FFFE; // beq $1,$1,-2
        rom[6]    = 32'h0800_03FF; // j 0x3FF
        rom[1023] = 32'h1021_0008; // beq $1,$1,+8
        rom[8]    = 32'h1020_0005; // beq $1,$0,+5
        apply_reset();
        tick(5);
        tick(3);
        checks++; if (imem_addr !== 10'd7 || dut.state !== FETCH) begin errors++; $display("[TB] FAIL j_target got pc %0d state %0d want 7/0", imem_addr, dut.state); end
        tick(4);
        checks++; if (imem_addr !== 10'd6 || dut.state !== FETCH) begin errors++; $display("[TB] FAIL beq_taken_back got pc %0d state %0d want 6/0", imem_addr, dut.state); end
        tick(3);
        checks++; if (imem_addr !== 10'd1023) begin errors++; $display("[TB] FAIL j_max got pc %0d want 1023", imem_addr); end
        tick(2);
        checks++; if (imem_addr !== 10'd0) begin errors++; $display("[TB] FAIL pc_wrap got pc %0d want 0", imem_addr); end
        tick(2);
        checks++; if (imem_addr !== 10'd8 || dut.state !== FETCH) begin errors++; $display("[TB] FAIL beq_taken_fwd got pc %0d state %0d want 8/0", imem_addr, dut.state); end
        tick(4);
        checks++; if (imem_addr !== 10'd9 || dut.state !== FETCH) begin errors++; $display("[TB] FAIL beq_not_taken got pc %0d state %0d want 9/0", imem_addr, dut.state); end
    endtask

    task automatic test_reset_during_mem();
        clear_rom();
        rom[0] = 32'h8C04_0004; // lw $4,4($0)
        apply_reset();
        stall = 1'b1;
        tick(5);
        checks++; if (r_en !== 1'b1 || dut.state !== MEM) begin errors++; $display("[TB] FAIL mem_stalled got r%b state %0d want 1/4", r_en, dut.state); end
        rst = 1'b1;
        tick(1);
        checks++; if (r_en !== 1'b0 || w_en !== 1'b0 || dut.state !== FETCH || imem_addr !== 10'd0) begin errors++; $display("[TB] FAIL rst_in_mem got r%b w%b state %0d pc %0d want 0/0/0/0", r_en, w_en, dut.state, imem_addr); end
        checks++; if (address !== 12'd0) begin errors++; $display("[TB] FAIL rst_in_mem_addr got %h want 0", address); end
        rst = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        stall = 1'b0;
        saida_cache = 32'd0;
`ifdef MIPS_DEBUG_PORT_EN
        dbg_sel = 5'd0;
`endif
        test_reset();
        test_alu();
        test_store_stall();
        test_branch_jump();
        test_reset_during_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multi_core.md
Name: mips_multi_core

Overview:
- Parametrised multicycle MIPS-subset core. Next generation of the board MIPS.
- Fetches from a synchronous instruction ROM.
- Issues data loads and stores to the cache through a stall handshake.
- Adds sign-extended immediates, corrected branch arithmetic, AND/OR/SLT, an illegal-opcode flag and an optional register debug port.

Parameters:
- PC_W, 10: instruction word-address width.
- ADDR_W, 12: data word-address width presented to the cache.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1: core clock.
- rst  in  1: synchronous, active-high reset.
- imem_addr  out  PC_W: instruction address (equals PC).
- imem_data  in  32: ROM output, valid one cycle after imem_addr.
- address  out  ADDR_W: data address to the cache.
- data  out  32: store data to the cache.
- r_en  out  1: load request, active-high.
- w_en  out  1: store request, active-high.
- stall  in  1: cache busy; hold the request while high.
- saida_cache  in  32: load data, valid in the cycle stall is low.
- illegal  out  1: one-cycle pulse when an unknown opcode or funct is decoded.

Behaviour:
- Reset:
  - rst sampled high forces state FETCH and PC=RESET_PC.
  - IR, A, B, ALUOUT and MDR clear to 0; r_en=w_en=0; illegal=0; address=data=0.
  - Register file contents are cleared.
  - rst overrides everything, including a pending MEM/stall.
- States (3-bit encoding in the package): FETCH, LOADIR, DECODE, EXEC, MEM, WB.
- FETCH: imem_addr=PC. Next state LOADIR.
- LOADIR: IR<=imem_data; PC<=PC+1 (wraps modulo 2^PC_W). Next state DECODE.
- DECODE:
  - A<=R[rs], B<=R[rt], IMM<=sign-extend(IR[15:0]) to 32 bits.
  - j: PC<=IR[PC_W-1:0], then FETCH.
  - Unknown opcode or funct: illegal=1 for this cycle, then FETCH; no state change otherwise.
  - All other instructions go to EXEC.
- EXEC (ALUOUT, 32-bit, wrap, no overflow trap):
  - add: A+B. sub: A-B. and: A&B. or: A|B.
  - slt: signed A<B gives 1, else 0.
  - addi: A+IMM. lw/sw: ALUOUT<=A+IMM.
  - R-type and addi go to WB.
  - lw/sw go to MEM.
  - beq: if A==B then PC<=PC+IMM[PC_W-1:0], relative to the already-incremented PC. Then FETCH.
- MEM:
  - address=ALUOUT[ADDR_W-1:0].
  - lw: r_en=1. sw: w_en=1 and data=B.
  - While stall=1: stay in MEM with address, data and enables held stable.
  - First cycle with stall=0: the transfer completes.
    - lw: MDR<=saida_cache, then WB.
    - sw: FETCH.
  - r_en and w_en are never high outside MEM and never high together.
- WB:
  - lw writes R[rt]<=MDR.
  - addi writes R[rt]<=ALUOUT.
  - R-type writes R[rd]<=ALUOUT.
  - Writes to register 0 are discarded; R[0] always reads 0.
  - Next state FETCH.
- Latency with no stall: j 3 cycles; beq 4; R-type/addi/sw 5; lw 6. Each stall cycle adds 1.

Optional Feature:
- Macro: MIPS_DEBUG_PORT_EN.
- Defined:
  - Adds ports dbg_sel in 5 and dbg_data out 32.
  - dbg_data is a combinational read of R[dbg_sel], for board display.
  - Also adds dbg_state out 3 mirroring the FSM.
- Undefined: those ports are absent and the register file has exactly two read ports.

Decomposition:
- Package mips_pkg:
  - State encodings.
  - Opcode constants: R=000000, addi=001000, beq=000100, j=000010, lw=100011, sw=101011.
  - Funct constants: add=100000, sub=100010, and=100100, or=100101, slt=101010.
  - ALU-op typedef.
- One sub-module, mips_regfile:
  - 32x32, two asynchronous read ports (third under MIPS_DEBUG_PORT_EN).
  - One synchronous write port; R0 hardwired to zero; synchronous clear on rst.

Test Plan:
- Reset then ROM `addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2` -> R3=2 after 15 cycles; R2=0xFFFFFFFD.
- `sw $1,4($0)` with stall high 3 cycles -> w_en=1, address=4, data=5 held 4 cycles; FETCH on the 5th; r_en stays 0.
- `lw $4,4($0)` with saida_cache=0x1234 and stall=0 -> r_en for 1 cycle; R4=0x1234; 6 cycles total.
- beq taken at PC=7 with offset -2 -> next fetch PC=6. beq not taken -> PC=8. `j 0x3FF` -> PC=1023; the following LOADIR wraps PC to 0.
- `slt $5,$2,$1` (-3<5) -> R5=1. `addi $0,$0,9` -> R0 reads 0. Opcode 111111 -> illegal pulse for 1 cycle, no register change.
- rst asserted during MEM with stall=1 -> next cycle r_en=w_en=0, state FETCH, PC=RESET_PC.
